// File: rtl/button_port.sv
// CPU register block for debounced buttons: level register, sticky press events
// with clear-on-read, interrupt flag. Define BUTTON_AUTOREPEAT_EN for hold-to-repeat events.
module button_port #(
    parameter int unsigned BUTTON_COUNT        = 16,
    parameter int unsigned REPEAT_COUNTER_SIZE = 24,
    parameter int unsigned REPEAT_DELAY        = 12000000,
    parameter int unsigned REPEAT_PERIOD       = 2500000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BUTTON_COUNT-1:0] buttons_in,
    input  logic                    rd_en,
    input  logic                    rd_sel,
    output logic [15:0]             rd_data,
    output logic                    rd_valid,
    output logic                    irq
);

    logic [BUTTON_COUNT-1:0] r_prev;
    logic [BUTTON_COUNT-1:0] r_events;
    logic [15:0]             r_rd_data;
    logic                    r_rd_valid;
    logic                    r_irq;

    logic [BUTTON_COUNT-1:0] w_rise;
    logic [BUTTON_COUNT-1:0] w_clr;
    logic [BUTTON_COUNT-1:0] w_rep;
    logic [BUTTON_COUNT-1:0] w_events_next;
    logic [15:0]             w_rd_word;
    logic                    w_evt_read;

    // The clear mask is the pre-update snapshot, so edges and repeats landing in the
    // same cycle as a clearing read survive it.
    always_comb begin
        w_rise        = buttons_in & ~r_prev;
        w_evt_read    = rd_en & rd_sel;
        w_clr         = w_evt_read ? r_events : '0;
        w_events_next = (r_events & ~w_clr) | w_rise | w_rep;
    end

    always_comb begin
        w_rd_word = '0;
        if (rd_sel) begin
            w_rd_word[BUTTON_COUNT-1:0] = r_events;
        end else begin
            w_rd_word[BUTTON_COUNT-1:0] = r_prev;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_events   <= '0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            r_prev     <= buttons_in;
            r_events   <= w_events_next;
            r_irq      <= |w_events_next;
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign irq      = r_irq;

`ifdef BUTTON_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_REPEAT
    } rpt_state_t;

    localparam logic [REPEAT_COUNTER_SIZE-1:0] LP_DELAY_LAST =
        (REPEAT_DELAY == 0) ? '0 : REPEAT_COUNTER_SIZE'(REPEAT_DELAY - 1);
    localparam logic [REPEAT_COUNTER_SIZE-1:0] LP_PERIOD_LAST =
        (REPEAT_PERIOD == 0) ? '0 : REPEAT_COUNTER_SIZE'(REPEAT_PERIOD - 1);

    rpt_state_t                     r_rpt_state;
    logic [REPEAT_COUNTER_SIZE-1:0] r_rpt_timer;
    logic                           w_changed;
    logic                           w_rpt_fire;

    // A change of the button set outranks any pending fire in the same cycle.
    always_comb begin
        w_changed  = (buttons_in != r_prev);
        w_rpt_fire = 1'b0;
        if (!w_changed) begin
            case (r_rpt_state)
                RPT_DELAY:  w_rpt_fire = (r_rpt_timer == LP_DELAY_LAST);
                RPT_REPEAT: w_rpt_fire = (r_rpt_timer == LP_PERIOD_LAST);
                default:    w_rpt_fire = 1'b0;
            endcase
        end
        w_rep = w_rpt_fire ? r_prev : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rpt_state <= RPT_IDLE;
            r_rpt_timer <= '0;
        end else if (w_changed) begin
            r_rpt_timer <= '0;
            r_rpt_state <= (|buttons_in) ? RPT_DELAY : RPT_IDLE;
        end else begin
            case (r_rpt_state)
                RPT_IDLE: begin
                    r_rpt_timer <= '0;
                end
                RPT_DELAY: begin
                    if (w_rpt_fire) begin
                        r_rpt_timer <= '0;
                        r_rpt_state <= RPT_REPEAT;
                    end else begin
                        r_rpt_timer <= r_rpt_timer + 1'b1;
                    end
                end
                RPT_REPEAT: begin
                    if (w_rpt_fire) begin
                        r_rpt_timer <= '0;
                    end else begin
                        r_rpt_timer <= r_rpt_timer + 1'b1;
                    end
                end
                default: begin
                    r_rpt_state <= RPT_IDLE;
                    r_rpt_timer <= '0;
                end
            endcase
        end
    end
`else
    assign w_rep = '0;
`endif

endmodule

// File: tb/tb_button_port.sv
// Directed self-checking bench for button_port (16-button and 4-button instances).
module tb_button_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] buttons;
    logic        rd_en;
    logic        rd_sel;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        irq;

    logic [3:0]  b_buttons;
    logic        b_rd_en;
    logic        b_rd_sel;
    logic [15:0] b_rd_data;
    logic        b_rd_valid;
    logic        b_irq;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    button_port #(
        .BUTTON_COUNT(16),
        .REPEAT_COUNTER_SIZE(8),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(4)
    ) u_dut (
        .clk(clk),
        .reset(reset),
        .buttons_in(buttons),
        .rd_en(rd_en),
        .rd_sel(rd_sel),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .irq(irq)
    );

    button_port #(
        .BUTTON_COUNT(4),
        .REPEAT_COUNTER_SIZE(8),
        .REPEAT_DELAY(10),
        .REPEAT_PERIOD(4)
    ) u_dut_narrow (
        .clk(clk),
        .reset(reset),
        .buttons_in(b_buttons),
        .rd_en(b_rd_en),
        .rd_sel(b_rd_sel),
        .rd_data(b_rd_data),
        .rd_valid(b_rd_valid),
        .irq(b_irq)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        rd_en   = 1'b0;
        rd_sel  = 1'b0;
        buttons = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Event mask generated at edge k of an autorepeat scenario (hand-derived).
    function automatic logic [15:0] exp_gen(int scen, int k);
        logic [15:0] m;
        m = '0;
`ifdef BUTTON_AUTOREPEAT_EN
        if (scen == 0) begin
            if (k == 0 || k == 10 || k == 14 || k == 18) m = 16'h0004;
        end else begin
            if (k == 0 || k == 10) m = 16'h0004;
            if (k == 13) m = 16'h0020;
            if (k == 23) m = 16'h0024;
        end
`else
        if (k == 0) m = 16'h0004;
        if (scen == 1 && k == 13) m = 16'h0020;
`endif
        return m;
    endfunction

    task automatic test_reset();
        reset = 1'b1; buttons = '0; rd_en = 1'b0; rd_sel = 1'b0;
        b_buttons = '0; b_rd_en = 1'b0; b_rd_sel = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            n_tests++;
            if (rd_data !== 16'h0000 || rd_valid !== 1'b0 || irq !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: rd_data=%h rd_valid=%b irq=%b, required 0000/0/0",
                         i, rd_data, rd_valid, irq);
            end
        end
        n_tests++;
        if (b_rd_data !== 16'h0000 || b_rd_valid !== 1'b0 || b_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_narrow: rd_data=%h rd_valid=%b irq=%b, required 0000/0/0",
                     b_rd_data, b_rd_valid, b_irq);
        end
    endtask

    task automatic test_press_read();
        buttons = 16'h0008;
        tick();
        n_tests++;
        if (irq !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL press_irq: irq=%b rd_valid=%b, required 1/0", irq, rd_valid);
        end
        tick();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL press_irq_hold: irq=%b, required 1", irq);
        end
        rd_en = 1'b1; rd_sel = 1'b1;
        tick();
        n_tests++;
        if (rd_data !== 16'h0008 || rd_valid !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL event_read: rd_data=%h rd_valid=%b irq=%b, required 0008/1/0",
                     rd_data, rd_valid, irq);
        end
        rd_en = 1'b0;
        tick();
        n_tests++;
        if (rd_data !== 16'h0008 || rd_valid !== 1'b0 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL event_read_after: rd_data=%h rd_valid=%b irq=%b, required 0008/0/0",
                     rd_data, rd_valid, irq);
        end
        rd_en = 1'b1;
        tick();
        n_tests++;
        if (rd_data !== 16'h0000 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL event_reread: rd_data=%h rd_valid=%b, required 0000/1", rd_data, rd_valid);
        end
        rd_en = 1'b0;
        tick();
    endtask

    task automatic test_level_read();
        buttons = 16'h0000;
        tick();
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL release_no_event: irq=%b, required 0", irq);
        end
        buttons = 16'h8001;
        tick();
        rd_en = 1'b1; rd_sel = 1'b0;
        tick();
        n_tests++;
        if (rd_data !== 16'h8001 || rd_valid !== 1'b1 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL level_read: rd_data=%h rd_valid=%b irq=%b, required 8001/1/1",
                     rd_data, rd_valid, irq);
        end
        rd_en = 1'b0;
        tick();
        n_tests++;
        if (irq !== 1'b1) begin
            n_fail++;
            $display("FAIL level_read_keeps_events: irq=%b, required 1", irq);
        end
        rd_en = 1'b1; rd_sel = 1'b1;
        tick();
        n_tests++;
        if (rd_data !== 16'h8001 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL level_then_event: rd_data=%h irq=%b, required 8001/0", rd_data, irq);
        end
        rd_en = 1'b0; buttons = 16'h0000;
        tick();
    endtask

    task automatic test_back_to_back();
        buttons = 16'h0002;
        tick();
        buttons = 16'h0006; rd_en = 1'b1; rd_sel = 1'b1;
        tick();
        n_tests++;
        if (rd_data !== 16'h0002 || rd_valid !== 1'b1 || irq !== 1'b1) begin
            n_fail++;
            $display("FAIL same_cycle_read: rd_data=%h rd_valid=%b irq=%b, required 0002/1/1",
                     rd_data, rd_valid, irq);
        end
        tick();
        n_tests++;
        if (rd_data !== 16'h0004 || rd_valid !== 1'b1 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_kept: rd_data=%h rd_valid=%b irq=%b, required 0004/1/0",
                     rd_data, rd_valid, irq);
        end
        rd_en = 1'b0;
        tick();
        n_tests++;
        if (rd_data !== 16'h0004 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_valid_drop: rd_data=%h rd_valid=%b, required 0004/0", rd_data, rd_valid);
        end
    endtask

    task automatic test_narrow();
        b_buttons = 4'hF;
        tick();
        b_rd_en = 1'b1; b_rd_sel = 1'b0;
        tick();
        n_tests++;
        if (b_rd_data !== 16'h000F || b_rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL narrow_level: rd_data=%h rd_valid=%b, required 000F/1", b_rd_data, b_rd_valid);
        end
        b_rd_sel = 1'b1;
        tick();
        n_tests++;
        if (b_rd_data !== 16'h000F || b_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL narrow_event: rd_data=%h irq=%b, required 000F/0", b_rd_data, b_irq);
        end
        b_rd_en = 1'b0; b_buttons = 4'h0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        buttons = 16'h0007;
        tick();
        rd_en = 1'b1; rd_sel = 1'b1; reset = 1'b1;
        tick();
        n_tests++;
        if (rd_valid !== 1'b0 || rd_data !== 16'h0000 || irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_read: rd_data=%h rd_valid=%b irq=%b, required 0000/0/0",
                     rd_data, rd_valid, irq);
        end
        rd_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (irq !== 1'b1 || rd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL held_through_reset: irq=%b rd_valid=%b, required 1/0", irq, rd_valid);
        end
        rd_en = 1'b1;
        tick();
        n_tests++;
        if (rd_data !== 16'h0007 || rd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL held_reset_event: rd_data=%h rd_valid=%b, required 0007/1", rd_data, rd_valid);
        end
        rd_en = 1'b0;
        tick();
        n_tests++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL held_reset_single: irq=%b, required 0", irq);
        end
        buttons = 16'h0000;
        tick();
    endtask

    task automatic test_autorepeat(input int scen);
        int n_cycles;
        logic [15:0] exp_rd;
        n_cycles = (scen == 0) ? 30 : 27;
        do_reset();
        rd_en = 1'b1; rd_sel = 1'b1;
        for (int k = 0; k < n_cycles; k++) begin
            if (scen == 0) buttons = (k < 20) ? 16'h0004 : 16'h0000;
            else           buttons = (k < 13) ? 16'h0004 : 16'h0024;
            tick();
            exp_rd = (k == 0) ? 16'h0000 : exp_gen(scen, k - 1);
            n_tests++;
            if (irq !== (exp_gen(scen, k) != 16'h0000) || rd_data !== exp_rd) begin
                n_fail++;
                $display("FAIL repeat_s%0d edge %0d: irq=%b rd_data=%h, required %b/%h",
                         scen, k, irq, rd_data, (exp_gen(scen, k) != 16'h0000), exp_rd);
            end
        end
        rd_en = 1'b0; buttons = 16'h0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_press_read();
        test_level_read();
        test_back_to_back();
        test_narrow();
        test_reset_mid_read();
        test_autorepeat(0);
        test_autorepeat(1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
